// File: rtl/branch_metric_unit.sv
// -----------------------------------------------------------------------------
// branch_metric_unit
//   Branch-metric unit for a Viterbi decoder front end. Each transfer carries
//   one rate-1/N soft symbol (N signed W-bit samples). The unit produces all
//   2^N branch metrics, normalised so the best metric is 0, and saturated to
//   MW unsigned bits. Soft (correlation) and hard (Hamming) modes are
//   selected per symbol. Three-stage pipeline with valid/ready flow control.
//
// Ports
//   CLK        clock, all logic on posedge
//   RST        synchronous reset, active-high
//   in_valid   in_sym/in_last/mode valid
//   in_ready   unit accepts a symbol this cycle
//   in_sym     N samples, sample i at bits [i*W +: W]
//   in_last    symbol is last of its frame
//   mode       0 = soft metrics, 1 = hard (Hamming) metrics
//   out_valid  out_bm/out_last valid
//   out_ready  downstream accepts
//   out_bm     metric for codeword k at bits [k*MW +: MW]
//   out_last   in_last delayed with its symbol
//   sym_count  output symbols transferred in the current frame
// -----------------------------------------------------------------------------
module branch_metric_unit #(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int MW = 10,
    parameter int CW = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*W-1:0]            in_sym,
    input  logic                      in_last,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1<<N)*MW-1:0]      out_bm,
    output logic                      out_last,
    output logic [CW-1:0]             sym_count
);

    localparam int K  = 1 << N;
    // Raw metric width: -2*r needs W+2 signed bits, summing N terms adds clog2(N).
    localparam int RW = W + 2 + $clog2(N);
    // One extra bit so raw - min can never wrap.
    localparam int DW = RW + 1;

    // Raw metric of codeword k; bit i of k is the expected code bit for sample i.
    function automatic logic signed [RW-1:0] raw_metric(input logic [N*W-1:0] sym,
                                                        input logic           hard,
                                                        input int             k);
        logic signed [RW-1:0] acc;
        logic signed [RW-1:0] rx;
        logic signed [W-1:0]  r;
        logic [N-1:0]         kb;
        acc = '0;
        kb  = N'(k);
        for (int i = 0; i < N; i++) begin
            r  = sym[i*W +: W];
            rx = {{(RW-W){r[W-1]}}, r};
            if (hard) begin
                // Hard decision: r >= 0 decodes as 1, so h_i is the inverted sign bit.
                acc = acc + RW'(kb[i] ^ ~r[W-1]);
            end else if (kb[i]) begin
                acc = acc - (rx <<< 1);
            end
        end
        return acc;
    endfunction

    // Clamp a non-negative normalised metric to the MW-bit output range.
    function automatic logic [MW-1:0] sat_metric(input logic signed [DW-1:0] d);
        logic [63:0] du;
        du = 64'(unsigned'(d));
        if (du > ((64'd1 << MW) - 64'd1)) begin
            return '1;
        end
        return du[MW-1:0];
    endfunction

    logic en;

    logic                 vld_p0_q, vld_p0_d;
    logic [N*W-1:0]       sym_p0_q, sym_p0_d;
    logic                 last_p0_q, last_p0_d;
    logic                 mode_p0_q, mode_p0_d;

    logic                 vld_p1_q, vld_p1_d;
    logic signed [RW-1:0] raw_p1_q [K];
    logic signed [RW-1:0] raw_p1_d [K];
    logic signed [RW-1:0] min_p1_q, min_p1_d;
    logic                 last_p1_q, last_p1_d;

    logic                 vld_p2_q, vld_p2_d;
    logic [K*MW-1:0]      bm_p2_q, bm_p2_d;
    logic                 last_p2_q, last_p2_d;

    logic [CW-1:0]        cnt_q, cnt_d;

    logic signed [RW-1:0] raw_c [K];
    logic signed [RW-1:0] min_c;

    assign en        = ~vld_p2_q | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2_q;
    assign out_bm    = bm_p2_q;
    assign out_last  = last_p2_q;
    assign sym_count = cnt_q;

    // S2 combinational: raw metrics for every codeword and their minimum.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            raw_c[k] = raw_metric(sym_p0_q, mode_p0_q, k);
        end
        min_c = raw_c[0];
        for (int k = 1; k < K; k++) begin
            if (raw_c[k] < min_c) begin
                min_c = raw_c[k];
            end
        end
    end

    always_comb begin
        vld_p0_d  = vld_p0_q;
        sym_p0_d  = sym_p0_q;
        last_p0_d = last_p0_q;
        mode_p0_d = mode_p0_q;
        vld_p1_d  = vld_p1_q;
        raw_p1_d  = raw_p1_q;
        min_p1_d  = min_p1_q;
        last_p1_d = last_p1_q;
        vld_p2_d  = vld_p2_q;
        bm_p2_d   = bm_p2_q;
        last_p2_d = last_p2_q;
        cnt_d     = cnt_q;

        if (en) begin
            // S1: capture the symbol and the mode it travels with.
            vld_p0_d  = in_valid;
            sym_p0_d  = in_sym;
            last_p0_d = in_last;
            mode_p0_d = mode;
            // S2: raw metrics and minimum.
            vld_p1_d  = vld_p0_q;
            raw_p1_d  = raw_c;
            min_p1_d  = min_c;
            last_p1_d = last_p0_q;
            // S3: normalise and saturate.
            vld_p2_d  = vld_p1_q;
            last_p2_d = last_p1_q;
            for (int k = 0; k < K; k++) begin
                bm_p2_d[k*MW +: MW] = sat_metric({raw_p1_q[k][RW-1], raw_p1_q[k]} -
                                                 {min_p1_q[RW-1], min_p1_q});
            end
        end

        if (vld_p2_q && out_ready) begin
            cnt_d = last_p2_q ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            bm_p2_q   <= '0;
            last_p2_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            bm_p2_q   <= bm_p2_d;
            last_p2_q <= last_p2_d;
            cnt_q     <= cnt_d;
        end
    end

    // Inner stage data needs no reset; the valid bits qualify it.
    always_ff @(posedge CLK) begin
        sym_p0_q  <= sym_p0_d;
        last_p0_q <= last_p0_d;
        mode_p0_q <= mode_p0_d;
        raw_p1_q  <= raw_p1_d;
        min_p1_q  <= min_p1_d;
        last_p1_q <= last_p1_d;
    end

endmodule

// File: tb/tb_branch_metric_unit.sv
module tb_branch_metric_unit;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int MW = 9;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_sym;
    logic          in_last;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [35:0]   out_bm;
    logic          out_last;
    logic [CW-1:0] sym_count;

    typedef struct packed {
        logic [35:0] bm;
        logic        last;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          stall_prev = 1'b0;
    logic [35:0]   prev_bm = '0;

    branch_metric_unit #(.W(W), .N(N), .MW(MW), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bm    (out_bm),
        .out_last  (out_last),
        .sym_count (sym_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $error("FAIL timeout observed no finish expected finish before 200000");
        $fatal(1, "simulation time limit reached");
    end

    // Reference metrics computed with plain integer arithmetic.
    function automatic logic [35:0] model(input logic [15:0] s, input logic m);
        int raw[4];
        int mn, r, c, h, v;
        logic [35:0] res;
        for (int k = 0; k < 4; k++) begin
            raw[k] = 0;
            for (int i = 0; i < 2; i++) begin
                r = int'($signed(s[i*8 +: 8]));
                c = (k >> i) & 1;
                if (m) begin
                    h = (r >= 0) ? 1 : 0;
                    raw[k] += (c != h) ? 1 : 0;
                end else if (c == 1) begin
                    raw[k] -= 2 * r;
                end
            end
        end
        mn = raw[0];
        for (int k = 1; k < 4; k++) if (raw[k] < mn) mn = raw[k];
        res = '0;
        for (int k = 0; k < 4; k++) begin
            v = raw[k] - mn;
            if (v > 511) v = 511;
            res[k*9 +: 9] = 9'(v);
        end
        return res;
    endfunction

    // Output monitor: scoreboard pops, hold-under-stall and frame counter.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            checks++;
            assert (sym_count === exp_cnt) else begin
                errors++;
                $error("FAIL sym_count observed %0d expected %0d", sym_count, exp_cnt);
            end
            if (stall_prev) begin
                checks++;
                assert (out_valid === 1'b1 && out_bm === prev_bm) else begin
                    errors++;
                    $error("FAIL stall_hold observed v=%b bm=%h expected v=1 bm=%h",
                           out_valid, out_bm, prev_bm);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed bm=%h expected no output", out_bm);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (out_bm === e.bm) else begin
                        errors++;
                        $error("FAIL out_bm observed %h expected %h", out_bm, e.bm);
                    end
                    checks++;
                    assert (out_last === e.last) else begin
                        errors++;
                        $error("FAIL out_last observed %b expected %b", out_last, e.last);
                    end
                    exp_cnt = e.last ? '0 : exp_cnt + 1'b1;
                end
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_bm    = out_bm;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step(input logic v, input logic [15:0] s, input logic l, input logic m,
                        input logic ordy, input logic [35:0] e, output logic acc);
        exp_t x;
        in_valid  = v;
        in_sym    = s;
        in_last   = l;
        mode      = m;
        out_ready = ordy;
        @(negedge CLK);
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            x.bm   = e;
            x.last = l;
            sb.push_back(x);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] s, input logic l, input logic m, input logic [35:0] e);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            step(1'b1, s, l, m, 1'b1, e, acc);
            tries++;
        end while (!acc && tries < 20);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_accept observed no accept expected accept within 20 cycles");
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 36'h0, acc);
    endtask

    task automatic check_out_valid(input string tag, input logic expv);
        checks++;
        assert (out_valid === expv) else begin
            errors++;
            $error("FAIL %s observed out_valid=%b expected %b", tag, out_valid, expv);
        end
    endtask

    // Called right after an accepting edge: out_valid must rise on the third cycle.
    task automatic check_latency(input string tag);
        @(negedge CLK); check_out_valid(tag, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK); check_out_valid(tag, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK); check_out_valid(tag, 1'b1);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [15:0] s;
        logic        m;
        logic        acc;
        int          idx, cyc;

        RST = 1'b1; in_valid = 1'b0; in_sym = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK);
        checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid observed %b expected 0", out_valid); end
        checks++; assert (out_bm === 36'h0) else begin errors++; $error("FAIL rst_out_bm observed %h expected 0", out_bm); end
        checks++; assert (out_last === 1'b0) else begin errors++; $error("FAIL rst_out_last observed %b expected 0", out_last); end
        checks++; assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready observed %b expected 1", in_ready); end
        @(posedge CLK); #1;

        // Soft: r0=+10, r1=-20 -> 20, 0, 60, 40
        send({8'hEC, 8'h0A}, 1'b0, 1'b0, {9'd40, 9'd60, 9'd0, 9'd20});
        check_latency("soft_latency");
        // Hard, same samples -> 1, 0, 2, 1
        send({8'hEC, 8'h0A}, 1'b0, 1'b1, {9'd1, 9'd2, 9'd0, 9'd1});
        check_latency("hard_latency");
        // Soft, r0=r1=-128 -> 0, 256, 256, 511 (saturated)
        send(16'h8080, 1'b0, 1'b0, {9'd511, 9'd256, 9'd256, 9'd0});
        // Extremes and zero samples back-to-back, alternating mode
        send(16'h7F80, 1'b0, 1'b0, model(16'h7F80, 1'b0));
        send(16'h0000, 1'b0, 1'b1, model(16'h0000, 1'b1));
        send(16'h0000, 1'b0, 1'b0, model(16'h0000, 1'b0));
        send(16'h8001, 1'b0, 1'b1, model(16'h8001, 1'b1));
        idle(6);

        // Backpressure: 6 symbols, out_ready low for cycles 4-7
        idx = 0;
        cyc = 0;
        while ((idx < 6 || cyc < 9) && cyc < 40) begin
            s = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            step(idx < 6, s, 1'b0, m, !(cyc >= 4 && cyc <= 7), model(s, m), acc);
            if (cyc >= 4 && cyc <= 7) begin
                checks++;
                assert (acc === 1'b0) else begin
                    errors++;
                    $error("FAIL stall_in_ready observed accept at cycle %0d expected in_ready=0", cyc);
                end
            end
            if (acc) idx++;
            cyc++;
        end
        out_ready = 1'b1;
        idle(6);
        checks++;
        assert (sb.size() === 0) else begin errors++; $error("FAIL stall_drain observed %0d pending expected 0", sb.size()); end

        // Frame tracking: close the current frame, then a 5-symbol and a 9-symbol frame
        send(16'h1234, 1'b1, 1'b0, model(16'h1234, 1'b0));
        for (int i = 0; i < 5; i++) begin
            s = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            send(s, i == 4, m, model(s, m));
        end
        for (int i = 0; i < 9; i++) begin
            s = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            send(s, i == 8, m, model(s, m));
        end
        idle(6);
        checks++;
        assert (sym_count === 3'd0) else begin errors++; $error("FAIL frame_end_count observed %0d expected 0", sym_count); end

        // Reset with two symbols in flight
        send(16'h0A0A, 1'b0, 1'b0, model(16'h0A0A, 1'b0));
        send(16'hF0F0, 1'b0, 1'b0, model(16'hF0F0, 1'b0));
        RST = 1'b1;
        sb.delete();
        exp_cnt = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_out_valid observed %b expected 0", out_valid); end
        checks++; assert (out_bm === 36'h0) else begin errors++; $error("FAIL midrst_out_bm observed %h expected 0", out_bm); end
        checks++; assert (sym_count === 3'd0) else begin errors++; $error("FAIL midrst_sym_count observed %0d expected 0", sym_count); end
        checks++; assert (in_ready === 1'b1) else begin errors++; $error("FAIL midrst_in_ready observed %b expected 1", in_ready); end
        @(posedge CLK); #1;
        send({8'h05, 8'hFB}, 1'b0, 1'b0, model({8'h05, 8'hFB}, 1'b0));
        check_latency("post_rst_latency");
        idle(6);

        checks++;
        assert (sb.size() === 0) else begin errors++; $error("FAIL final_drain observed %0d pending expected 0", sb.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
